// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch front end.
// Issues in-order fetches, tags them with their PC, buffers returned words
// in a small queue for decode, and discards stale work on EX redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    // PC generator and in-flight tag FIFO
    logic [31:0]      r_pc;
    logic [31:0]      r_tag [DEPTH];
    logic [PTR_W-1:0] r_tag_wr;
    logic [PTR_W-1:0] r_tag_rd;
    logic [CNT_W-1:0] r_inflight;

    // Decode queue and stale-response drop counter
    logic [31:0]      r_q_pc    [DEPTH];
    logic [31:0]      r_q_instr [DEPTH];
    logic [PTR_W-1:0] r_q_wr;
    logic [PTR_W-1:0] r_q_rd;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_drop;

    logic [CNT_W:0]   w_occ;
    logic             w_fire;
    logic             w_rsp_keep;
    logic             w_q_pop;
    logic [CNT_W-1:0] w_inflight_nxt;

    // Dropped-but-outstanding fetches still count against occupancy, so the
    // queue always has room for every response that will actually be kept.
    assign w_occ          = {1'b0, r_inflight} + {1'b0, r_count};
    assign imem_req_valid = CPU_RST && !redirect_valid && (w_occ < DEPTH_OCC);
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_rsp_keep     = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_q_pop        = id_valid && id_ready && !redirect_valid;
    assign w_inflight_nxt = r_inflight + CNT_W'(w_fire) - CNT_W'(imem_rsp_valid);

    // Decode sees queue registers only; nothing from imem_rsp reaches id_*.
    assign id_valid = (r_count != '0);
    assign id_pc    = r_q_pc[r_q_rd];
    assign id_instr = r_q_instr[r_q_rd];

    // PC advance / redirect, tag FIFO push on fire, pop on every response
    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            r_pc       <= RESET_PC;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_inflight <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_tag[i] <= '0;
        end else begin
            if (redirect_valid)
                r_pc <= {redirect_pc[31:2], 2'b00};
            else if (w_fire)
                r_pc <= r_pc + 32'd4;
            if (w_fire) begin
                r_tag[r_tag_wr] <= r_pc;
                r_tag_wr        <= r_tag_wr + PTR_W'(1);
            end
            // Stale tags stay in the FIFO and drain with their responses.
            if (imem_rsp_valid)
                r_tag_rd <= r_tag_rd + PTR_W'(1);
            r_inflight <= w_inflight_nxt;
        end
    end

    // Decode queue push/pop, flush on redirect, stale-response accounting
    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_count <= '0;
            r_drop  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_count <= '0;
            // Everything still outstanding after this edge is stale; a
            // response landing in the redirect cycle is already excluded.
            r_drop  <= w_inflight_nxt;
        end else begin
            if (w_rsp_keep) begin
                r_q_pc[r_q_wr]    <= r_tag[r_tag_rd];
                r_q_instr[r_q_wr] <= imem_rsp_data;
                r_q_wr            <= r_q_wr + PTR_W'(1);
            end
            if (w_q_pop)
                r_q_rd <= r_q_rd + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_rsp_keep) - CNT_W'(w_q_pop);
            if (imem_rsp_valid && (r_drop != '0))
                r_drop <= r_drop - CNT_W'(1);
        end
    end

    a_no_overflow: assert property (@(posedge CPU_CLK) disable iff (!CPU_RST)
        !(w_rsp_keep && !w_q_pop && (r_count == CNT_W'(DEPTH))));
    a_occ_bound: assert property (@(posedge CPU_CLK) disable iff (!CPU_RST)
        w_occ <= DEPTH_OCC);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scenario tasks driving fetch_stage against a 1-cycle
// in-order memory model and an expected-output scoreboard.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_instr(id_instr)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] pend[$];          // memory model: accepted addresses
    logic [63:0] sb[$];            // expected {pc, instr} for decode
    logic [31:0] exp_pc;
    int          nfire;
    int          nid;
    bit          ff_seen;
    logic [31:0] ff_addr;
    bit          fid_seen;
    logic [31:0] fid_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic clear_marks();
        nfire = 0; nid = 0; ff_seen = 0; fid_seen = 0;
        ff_addr = '0; fid_pc = '0;
    endtask

    task automatic apply_reset();
        CPU_RST = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        redirect_valid = 0; redirect_pc = '0; id_ready = 0;
        pend.delete(); sb.delete();
        exp_pc = RESET_PC;
        clear_marks();
        repeat (2) @(negedge CPU_CLK);
        CPU_RST = 1'b1;
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, update models.
    task automatic step(input bit rdy, input bit idr, input bit rsp_en,
                        input bit redir, input logic [31:0] rpc);
        logic [63:0] e;
        @(negedge CPU_CLK);
        imem_req_ready = rdy; id_ready = idr;
        redirect_valid = redir; redirect_pc = rpc;
        if (rsp_en && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            checks++;
            if (imem_req_addr !== exp_pc) begin
                errors++;
                $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_pc);
            end
            if (!ff_seen) begin ff_seen = 1; ff_addr = imem_req_addr; end
            pend.push_back(exp_pc);
            sb.push_back({exp_pc, instr_of(exp_pc)});
            exp_pc = exp_pc + 32'd4;
            nfire++;
        end
        if (id_valid && id_ready && !redirect_valid) begin
            checks++;
            if (!fid_seen) begin fid_seen = 1; fid_pc = id_pc; end
            nid++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL id_unexpected: got pc %h expected no entry", id_pc);
            end else begin
                e = sb.pop_front();
                if (id_pc !== e[63:32] || id_instr !== e[31:0]) begin
                    errors++;
                    $display("FAIL id_entry: got %h/%h expected %h/%h",
                             id_pc, id_instr, e[63:32], e[31:0]);
                end
            end
        end
        if (redir) begin
            sb.delete();
            exp_pc = rpc & 32'hFFFF_FFFC;
        end
    endtask

    task automatic test_reset();
        CPU_RST = 1'b0;
        #3;
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 ||
            id_pc !== 32'h0 || id_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%h/%h expected 0/0/0/0",
                     imem_req_valid, id_valid, id_pc, id_instr);
        end
        apply_reset();
        step(1, 1, 1, 0, '0);
        checks++;
        if (ff_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: got %h expected %h", ff_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        repeat (16) step(1, 1, 1, 0, '0);
        checks++;
        if (nid < 6) begin
            errors++;
            $display("FAIL stream_count: got %0d expected >= 6", nid);
        end
        checks++;
        if (fid_pc !== 32'h0) begin
            errors++;
            $display("FAIL stream_first_pc: got %h expected 00000000", fid_pc);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        repeat (6) step(1, 0, 1, 0, '0);
        checks++;
        if (nfire != 2) begin
            errors++;
            $display("FAIL bp_fires: got %0d expected 2", nfire);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid);
        end
        repeat (10) step(1, 1, 1, 0, '0);
        checks++;
        if (nid < 4 || exp_pc <= 32'h8) begin
            errors++;
            $display("FAIL bp_resume: got %0d ids next %h expected >= 4 ids past 8",
                     nid, exp_pc);
        end
    endtask

    task automatic test_req_stall();
        apply_reset();
        step(1, 1, 1, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, '0);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
                errors++;
                $display("FAIL stall_hold: got %b/%h expected 1/00000004",
                         imem_req_valid, imem_req_addr);
            end
        end
        step(1, 1, 1, 0, '0);
        step(0, 1, 1, 0, '0);
        checks++;
        if (imem_req_addr !== 32'h8) begin
            errors++;
            $display("FAIL stall_advance: got %h expected 00000008", imem_req_addr);
        end
        repeat (4) step(1, 1, 1, 0, '0);
    endtask

    task automatic test_redirect_inflight();
        apply_reset();
        repeat (3) step(1, 1, 0, 0, '0);
        checks++;
        if (nfire != 2) begin
            errors++;
            $display("FAIL redir_setup: got %0d fires expected 2", nfire);
        end
        step(1, 1, 0, 1, 32'h0000_0103);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_no_req: got %b expected 0", imem_req_valid);
        end
        clear_marks();
        repeat (10) step(1, 1, 1, 0, '0);
        checks++;
        if (ff_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_next_req: got %h expected 00000100", ff_addr);
        end
        checks++;
        if (fid_pc !== 32'h100) begin
            errors++;
            $display("FAIL redir_first_id: got %h expected 00000100", fid_pc);
        end
    endtask

    task automatic test_redirect_rsp();
        apply_reset();
        step(1, 0, 1, 0, '0);
        step(1, 0, 1, 0, '0);
        step(1, 1, 1, 1, 32'h0000_0200);
        checks++;
        if (imem_rsp_valid !== 1'b1 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_setup: got rsp %b id_valid %b expected 1/1",
                     imem_rsp_valid, id_valid);
        end
        clear_marks();
        repeat (8) step(1, 1, 1, 0, '0);
        checks++;
        if (fid_pc !== 32'h200) begin
            errors++;
            $display("FAIL rr_first_id: got %h expected 00000200", fid_pc);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        step(1, 1, 1, 1, 32'hFFFF_FFFE);
        clear_marks();
        repeat (10) step(1, 1, 1, 0, '0);
        checks++;
        if (fid_pc !== 32'hFFFF_FFFC || nid < 3) begin
            errors++;
            $display("FAIL wrap: got first %h count %0d expected fffffffc >= 3",
                     fid_pc, nid);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (4) step(1, 0, 1, 0, '0);
        checks++;
        if (id_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_setup: got id_valid %b expected 1", id_valid);
        end
        @(posedge CPU_CLK);
        #3;
        CPU_RST = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_drop: got %b/%b expected 0/0", id_valid, imem_req_valid);
        end
        apply_reset();
        repeat (6) step(1, 1, 1, 0, '0);
        checks++;
        if (ff_addr !== RESET_PC || fid_pc !== RESET_PC) begin
            errors++;
            $display("FAIL ar_restart: got %h/%h expected %h", ff_addr, fid_pc, RESET_PC);
        end
    endtask

    initial begin
        exp_pc = RESET_PC;
        clear_marks();
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_inflight();
        test_redirect_rsp();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
